cpu_state_sequencer: RTL
========================

Name: cpu_state_sequencer

Overview:
One-hot control-state generator for the complex CPU: the producer end of the 40-bit `state` bus consumed by the register-select, ALU and datapath-enable logic. Steps every instruction through fetch, decode and an opcode-specific execute sequence. Waits on memory handshakes, counts retired instructions, and traps on illegal opcodes or memory timeout.

Parameters:
STATE_W, 40, width of one-hot state vector (fixed; bit map below assumes 40)
MEM_TIMEOUT, 255, max cycles a wait state holds without mem_ready before FAULT (1..65535)
RET_W, 32, width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
opcode  input  4  IR[31:28], sampled only in DECODE
mem_ready  input  1  memory handshake; read/write completes in cycle it is high
zero_flag  input  1  ALU Z flag, sampled in BEQ state
state  output  STATE_W  one-hot control state, registered
last_cycle  output  1  combinational; high in final state of current instruction
retired  output  RET_W  count of completed instructions, registered
halted  output  1  state == HALT
fault  output  1  state == FAULT
branch_taken  output  1  registered; set for one cycle after BEQ with zero_flag=1 or after BRA

Behaviour:
- Reset (async): state = 1<<0 (FETCH1), retired = 0, branch_taken = 0, timeout counter = 0. Reset mid-instruction abandons it; no retire.
- Bit map: 0 FETCH1, 1 FETCH2 (mem wait), 2 FETCH3, 3 DECODE; 4 LDR1, 5 LDR2 (mem wait), 6 LDR3; 7 STR1, 8 STR2 (mem wait); 10 MOV1; 11 BRA1; 12 BEQ1; 26/27 ADD1/ADD2; 28/29 SUB1/SUB2; 30/31 MUL1/MUL2; 32/33 LSR1/LSR2; 34/35 AND1/AND2; 36/37 OR1/OR2; 38 FAULT; 39 HALT. All other bits are never set.
- Fixed flow: FETCH1 -> FETCH2 -> FETCH3 -> DECODE, one cycle each.
- Wait states (1, 5, 8): advance when mem_ready=1, else hold.
- DECODE dispatch:
  - 0x0 NOP -> FETCH1
  - 0x1 -> LDR1; 0x2 -> STR1; 0x3 -> MOV1; 0x4 -> BRA1; 0x5 -> BEQ1
  - 0x6..0xB -> ADD1, SUB1, MUL1, LSR1, AND1, OR1
  - 0xC -> HALT; 0xD..0xF -> FAULT
- Sequences: LDR1->LDR2->LDR3->FETCH1; STR1->STR2->FETCH1; MOV1, BRA1, BEQ1 -> FETCH1; each ALU op X1->X2->FETCH1.
- last_cycle high in: DECODE with opcode 0x0, LDR3, STR2 with mem_ready=1, MOV1, BRA1, BEQ1, any X2. Never high in HALT or FAULT.
- retired increments by 1 on every transition into FETCH1 from a last_cycle state. It wraps modulo 2^RET_W and is not incremented by reset.
- Timeout:
  - Counter clears on entering any wait state and increments each cycle the wait state holds with mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready=0, the next state is FAULT.
  - mem_ready=1 in the same cycle as the limit wins (normal advance).
- HALT and FAULT are sticky until rst. HALT is entered only via opcode 0xC; it does not retire.
- branch_taken = 1 for the cycle after BRA1, or after BEQ1 with zero_flag=1. Otherwise 0.
- Invariant: $onehot(state) every cycle after reset. If a non-one-hot value is ever detected, the next state is FAULT.

Test Plan:
- Reset, opcode=0x0, mem_ready=1 always -> state bits 0,1,2,3,0 on consecutive cycles; retired=1 after 4 cycles post-reset.
- opcode=0x6 (ADD), mem_ready=1 -> sequence 0,1,2,3,26,27,0; last_cycle high only in the bit-27 cycle; retired increments once.
- LDR with mem_ready low 5 cycles in LDR2 -> state holds 1<<5 for 5 cycles, then 1<<6, then 1<<0; retired +1.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH2 -> FAULT (1<<38) after 4 hold cycles; fault=1 stays set until rst; retired unchanged.
- BEQ with zero_flag=1, then BEQ with zero_flag=0 -> branch_taken pulses one cycle only after the first.
- opcode=0xC -> HALT, halted=1 held 100 cycles. Then assert rst mid-HALT -> state=1<<0 and retired=0 immediately (asynchronous).

Source files
------------

// File: rtl/cpu_state_sequencer.sv
// One-hot control-state sequencer for the complex CPU.
// Drives fetch/decode/execute states, retires instructions, traps on faults.
module cpu_state_sequencer #(
  parameter int STATE_W     = 40,
  parameter int MEM_TIMEOUT = 255,
  parameter int RET_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         opcode,
  input  logic               mem_ready,
  input  logic               zero_flag,
  output logic [STATE_W-1:0] state,
  output logic               last_cycle,
  output logic [RET_W-1:0]   retired,
  output logic               halted,
  output logic               fault,
  output logic               branch_taken
);

  localparam int S_FETCH1 = 0;
  localparam int S_FETCH2 = 1;
  localparam int S_FETCH3 = 2;
  localparam int S_DECODE = 3;
  localparam int S_LDR1   = 4;
  localparam int S_LDR2   = 5;
  localparam int S_LDR3   = 6;
  localparam int S_STR1   = 7;
  localparam int S_STR2   = 8;
  localparam int S_MOV1   = 10;
  localparam int S_BRA1   = 11;
  localparam int S_BEQ1   = 12;
  localparam int S_ADD1   = 26;
  localparam int S_ADD2   = 27;
  localparam int S_SUB1   = 28;
  localparam int S_SUB2   = 29;
  localparam int S_MUL1   = 30;
  localparam int S_MUL2   = 31;
  localparam int S_LSR1   = 32;
  localparam int S_LSR2   = 33;
  localparam int S_AND1   = 34;
  localparam int S_AND2   = 35;
  localparam int S_OR1    = 36;
  localparam int S_OR2    = 37;
  localparam int S_FAULT  = 38;
  localparam int S_HALT   = 39;

  localparam logic [15:0] TO_LIM = 16'(MEM_TIMEOUT);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [STATE_W-1:0] w_dispatch;
  logic [STATE_W-1:0] w_state_m1;
  logic               w_onehot;
  logic [15:0]        r_to_cnt;
  logic               w_timeout;
  logic               w_in_wait;
  logic               w_enter_wait;
  logic [RET_W-1:0]   r_retired;
  logic               r_branch;

  assign state        = r_state;
  assign retired      = r_retired;
  assign branch_taken = r_branch;

  assign w_state_m1 = r_state - STATE_W'(1);
  assign w_onehot   = (|r_state) & ~(|(r_state & w_state_m1));
  assign w_timeout  = (r_to_cnt >= TO_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= STATE_W'(1);
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_dispatch = '0;
    case (opcode)
      4'h0:    w_dispatch[S_FETCH1] = 1'b1;
      4'h1:    w_dispatch[S_LDR1]   = 1'b1;
      4'h2:    w_dispatch[S_STR1]   = 1'b1;
      4'h3:    w_dispatch[S_MOV1]   = 1'b1;
      4'h4:    w_dispatch[S_BRA1]   = 1'b1;
      4'h5:    w_dispatch[S_BEQ1]   = 1'b1;
      4'h6:    w_dispatch[S_ADD1]   = 1'b1;
      4'h7:    w_dispatch[S_SUB1]   = 1'b1;
      4'h8:    w_dispatch[S_MUL1]   = 1'b1;
      4'h9:    w_dispatch[S_LSR1]   = 1'b1;
      4'hA:    w_dispatch[S_AND1]   = 1'b1;
      4'hB:    w_dispatch[S_OR1]    = 1'b1;
      4'hC:    w_dispatch[S_HALT]   = 1'b1;
      default: w_dispatch[S_FAULT]  = 1'b1;
    endcase
  end

  // Corrupted (non-one-hot) or unused-bit states fall into FAULT.
  always_comb begin
    w_next = '0;
    if (!w_onehot) begin
      w_next[S_FAULT] = 1'b1;
    end else begin
      unique case (1'b1)
        r_state[S_FETCH1]: w_next[S_FETCH2] = 1'b1;
        r_state[S_FETCH2]: begin
          if (mem_ready)      w_next[S_FETCH3] = 1'b1;
          else if (w_timeout) w_next[S_FAULT]  = 1'b1;
          else                w_next[S_FETCH2] = 1'b1;
        end
        r_state[S_FETCH3]: w_next[S_DECODE] = 1'b1;
        r_state[S_DECODE]: w_next = w_dispatch;
        r_state[S_LDR1]:   w_next[S_LDR2] = 1'b1;
        r_state[S_LDR2]: begin
          if (mem_ready)      w_next[S_LDR3]  = 1'b1;
          else if (w_timeout) w_next[S_FAULT] = 1'b1;
          else                w_next[S_LDR2]  = 1'b1;
        end
        r_state[S_LDR3]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_STR1]:   w_next[S_STR2] = 1'b1;
        r_state[S_STR2]: begin
          if (mem_ready)      w_next[S_FETCH1] = 1'b1;
          else if (w_timeout) w_next[S_FAULT]  = 1'b1;
          else                w_next[S_STR2]   = 1'b1;
        end
        r_state[S_MOV1]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_BRA1]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_BEQ1]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_ADD1]:   w_next[S_ADD2] = 1'b1;
        r_state[S_SUB1]:   w_next[S_SUB2] = 1'b1;
        r_state[S_MUL1]:   w_next[S_MUL2] = 1'b1;
        r_state[S_LSR1]:   w_next[S_LSR2] = 1'b1;
        r_state[S_AND1]:   w_next[S_AND2] = 1'b1;
        r_state[S_OR1]:    w_next[S_OR2]  = 1'b1;
        r_state[S_ADD2]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_SUB2]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_MUL2]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_LSR2]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_AND2]:   w_next[S_FETCH1] = 1'b1;
        r_state[S_OR2]:    w_next[S_FETCH1] = 1'b1;
        r_state[S_HALT]:   w_next[S_HALT]   = 1'b1;
        r_state[S_FAULT]:  w_next[S_FAULT]  = 1'b1;
        default:           w_next[S_FAULT]  = 1'b1;
      endcase
    end
  end

  always_comb begin
    last_cycle = 1'b0;
    halted     = 1'b0;
    fault      = 1'b0;
    if (w_onehot) begin
      halted     = r_state[S_HALT];
      fault      = r_state[S_FAULT];
      last_cycle = (r_state[S_DECODE] && opcode == 4'h0)
                 | r_state[S_LDR3]
                 | (r_state[S_STR2] && mem_ready)
                 | r_state[S_MOV1] | r_state[S_BRA1]
                 | r_state[S_BEQ1]
                 | r_state[S_ADD2] | r_state[S_SUB2]
                 | r_state[S_MUL2] | r_state[S_LSR2]
                 | r_state[S_AND2] | r_state[S_OR2];
    end
  end

  assign w_in_wait = r_state[S_FETCH2] | r_state[S_LDR2]
                   | r_state[S_STR2];
  assign w_enter_wait = (w_next[S_FETCH2] & ~r_state[S_FETCH2])
                      | (w_next[S_LDR2]   & ~r_state[S_LDR2])
                      | (w_next[S_STR2]   & ~r_state[S_STR2]);

  // Counter saturates so a very long stall cannot wrap past the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt <= '0;
    end else if (w_enter_wait) begin
      r_to_cnt <= '0;
    end else if (w_in_wait && !mem_ready && r_to_cnt != '1) begin
      r_to_cnt <= r_to_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_retired <= '0;
    end else if (last_cycle && w_next[S_FETCH1]) begin
      r_retired <= r_retired + RET_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_branch <= 1'b0;
    end else begin
      r_branch <= w_onehot &
                  (r_state[S_BRA1] | (r_state[S_BEQ1] & zero_flag));
    end
  end

endmodule
